// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank arbiter: JK op encodings and the
// command record carried from arbitration to the apply stage.
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // Fixed-width fields so one struct serves every parameterisation.
  localparam int CMD_ID_W  = 8;
  localparam int CMD_IDX_W = 8;

  typedef struct packed {
    logic [CMD_ID_W-1:0]  id;
    logic [CMD_IDX_W-1:0] idx;
    logic [1:0]           jk;
  } jk_cmd_t;

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester command bus plus exported JK bank state.
interface jk_bank_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*IDX_W-1:0] req_idx;
  logic [N_REQ*2-1:0]     req_jk;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       qb;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   err;

  modport master (
    output req_valid, req_idx, req_jk,
    input  req_ready, q, qb, done, busy, err
  );

  modport slave (
    input  req_valid, req_idx, req_jk,
    output req_ready, q, qb, done, busy, err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a rotating
// pointer; the pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int  N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] grant_idx_o
);
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[(int'(ptr_q) + i) % N]) begin
        found                           = 1'b1;
        grant_o[(int'(ptr_q) + i) % N]  = 1'b1;
        grant_idx_o                     = PTR_W'((int'(ptr_q) + i) % N);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (grant_idx_o == PTR_W'(N - 1)) ? '0 : grant_idx_o + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/jk_bank_arbiter.sv
// Bank of JK cells shared by N_REQ requesters: round-robin grant, one-stage
// command register, then JK update of the addressed cell.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  jk_bank_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int ID_W  = $clog2(N_REQ);

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             hs;

  jk_cmd_t          cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;

  assign bus.req_ready = rst ? '0 : grant;
  assign hs            = |(bus.req_valid & bus.req_ready);

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       (bus.req_valid),
    .advance_i   (hs),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_comb begin
    cmd_valid_d = hs;
    cmd_d.id    = CMD_ID_W'(grant_idx);
    cmd_d.idx   = CMD_IDX_W'(bus.req_idx[int'(grant_idx)*IDX_W +: IDX_W]);
    cmd_d.jk    = bus.req_jk[int'(grant_idx)*2 +: 2];
  end

  // An out-of-range index matches no cell, so it only raises err.
  always_comb begin
    q_d    = q_q;
    done_d = '0;
    err_d  = err_q;
    if (cmd_valid_q) begin
      if (cmd_q.idx >= CMD_IDX_W'(WIDTH)) err_d = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
        if (cmd_q.idx == CMD_IDX_W'(i)) begin
          case (cmd_q.jk)
            JK_HOLD: q_d[i] = q_q[i];
            JK_RST:  q_d[i] = 1'b0;
            JK_SET:  q_d[i] = 1'b1;
            JK_TOG:  q_d[i] = ~q_q[i];
          endcase
        end
      end
      for (int r = 0; r < N_REQ; r++) begin
        if (cmd_q.id == CMD_ID_W'(r)) done_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      q_q         <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      q_q         <= q_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.qb   = ~q_q;
  assign bus.done = done_q;
  assign bus.busy = cmd_valid_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: an 8-cell instance for the main
// function and a 6-cell instance for out-of-range indices.
module tb_jk_bank_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter_if #(.N_REQ(4), .WIDTH(8)) b8 ();
  jk_bank_arbiter_if #(.N_REQ(4), .WIDTH(6)) b6 ();

  jk_bank_arbiter #(.N_REQ(4), .WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  jk_bank_arbiter #(.N_REQ(4), .WIDTH(6)) u6 (.clk(clk), .rst(rst), .bus(b6));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set8(input int i, input logic [2:0] idx, input logic [1:0] jk);
    b8.req_valid[i]       = 1'b1;
    b8.req_idx[i*3 +: 3]  = idx;
    b8.req_jk[i*2 +: 2]   = jk;
  endtask

  task automatic clr8();
    b8.req_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b8.req_valid = '0;
    b6.req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b8.req_valid = 4'b1111;
    b6.req_valid = 4'b1111;
    tick();
    n_cmp++; if (b8.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready8 got=%b exp=0000", b8.req_ready); end
    n_cmp++; if (b6.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready6 got=%b exp=0000", b6.req_ready); end
    b8.req_valid = '0;
    b6.req_valid = '0;
    rst = 1'b0;
    tick();
    n_cmp++; if (b8.q !== 8'h00) begin n_err++; $display("FAIL reset_q got=%h exp=00", b8.q); end
    n_cmp++; if (b8.qb !== 8'hFF) begin n_err++; $display("FAIL reset_qb got=%h exp=ff", b8.qb); end
    n_cmp++; if (b8.done !== 4'b0000) begin n_err++; $display("FAIL reset_done got=%b exp=0000", b8.done); end
    n_cmp++; if (b8.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", b8.busy); end
    n_cmp++; if (b8.err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", b8.err); end
    $display("test_reset: done, mismatches so far %0d", n_err);
  endtask

  task automatic test_single();
    set8(0, 3'd3, 2'b10);
    #1;
    n_cmp++; if (b8.req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got=%b exp=0001", b8.req_ready); end
    tick();
    clr8();
    n_cmp++; if (b8.busy !== 1'b1) begin n_err++; $display("FAIL single_busy got=%b exp=1", b8.busy); end
    n_cmp++; if (b8.q !== 8'h00) begin n_err++; $display("FAIL single_q_early got=%h exp=00", b8.q); end
    n_cmp++; if (b8.done !== 4'b0000) begin n_err++; $display("FAIL single_done_early got=%b exp=0000", b8.done); end
    tick();
    n_cmp++; if (b8.q !== 8'h08) begin n_err++; $display("FAIL single_q got=%h exp=08", b8.q); end
    n_cmp++; if (b8.qb !== 8'hF7) begin n_err++; $display("FAIL single_qb got=%h exp=f7", b8.qb); end
    n_cmp++; if (b8.done !== 4'b0001) begin n_err++; $display("FAIL single_done got=%b exp=0001", b8.done); end
    n_cmp++; if (b8.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_off got=%b exp=0", b8.busy); end
    tick();
    n_cmp++; if (b8.done !== 4'b0000) begin n_err++; $display("FAIL single_done_pulse got=%b exp=0000", b8.done); end
    $display("test_single: idx=3 jk=10 q=%h", b8.q);
  endtask

  task automatic test_jk_table();
    logic [1:0] seq [6] = '{2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11};
    logic       exp [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_q;
    for (int k = 0; k < 6; k++) begin
      set8(0, 3'd0, seq[k]);
      tick();
      clr8();
      tick();
      exp_q = 8'h08 | {7'd0, exp[k]};
      n_cmp++; if (b8.q !== exp_q) begin n_err++; $display("FAIL jk_table_q step=%0d got=%h exp=%h", k, b8.q, exp_q); end
      n_cmp++; if (b8.qb !== ~exp_q) begin n_err++; $display("FAIL jk_table_qb step=%0d got=%h exp=%h", k, b8.qb, ~exp_q); end
      $display("test_jk_table: step %0d jk=%b q=%h", k, seq[k], b8.q);
    end
  endtask

  task automatic test_fairness();
    int         dcnt [4] = '{0, 0, 0, 0};
    logic [3:0] exp_done;
    do_reset();
    for (int i = 0; i < 4; i++) set8(i, 3'(i), 2'b11);
    #1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (b8.req_ready !== (4'b0001 << (k % 4))) begin n_err++; $display("FAIL fair_grant cycle=%0d got=%b exp=%b", k, b8.req_ready, 4'b0001 << (k % 4)); end
      tick();
      exp_done = (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4));
      n_cmp++; if (b8.done !== exp_done) begin n_err++; $display("FAIL fair_done cycle=%0d got=%b exp=%b", k, b8.done, exp_done); end
      if (k == 4) begin
        n_cmp++; if (b8.q !== 8'h0F) begin n_err++; $display("FAIL fair_q_mid got=%h exp=0f", b8.q); end
      end
      for (int i = 0; i < 4; i++) dcnt[i] += int'(b8.done[i]);
      $display("test_fairness: cycle %0d done=%b q=%h", k, b8.done, b8.q);
    end
    clr8();
    tick();
    for (int i = 0; i < 4; i++) dcnt[i] += int'(b8.done[i]);
    n_cmp++; if (b8.done !== 4'b1000) begin n_err++; $display("FAIL fair_done_last got=%b exp=1000", b8.done); end
    n_cmp++; if (b8.q !== 8'h00) begin n_err++; $display("FAIL fair_q_final got=%h exp=00", b8.q); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (dcnt[i] !== 2) begin n_err++; $display("FAIL fair_done_count r%0d got=%0d exp=2", i, dcnt[i]); end
    end
  endtask

  task automatic test_rotation();
    set8(2, 3'd1, 2'b00);
    #1;
    n_cmp++; if (b8.req_ready !== 4'b0100) begin n_err++; $display("FAIL rot_r2 got=%b exp=0100", b8.req_ready); end
    tick();
    clr8();
    set8(0, 3'd0, 2'b00);
    set8(3, 3'd0, 2'b00);
    #1;
    n_cmp++; if (b8.req_ready !== 4'b1000) begin n_err++; $display("FAIL rot_r3_first got=%b exp=1000", b8.req_ready); end
    tick();
    b8.req_valid[3] = 1'b0;
    #1;
    n_cmp++; if (b8.req_ready !== 4'b0001) begin n_err++; $display("FAIL rot_r0_second got=%b exp=0001", b8.req_ready); end
    tick();
    clr8();
    n_cmp++; if (b8.done !== 4'b1000) begin n_err++; $display("FAIL rot_done_r3 got=%b exp=1000", b8.done); end
    tick();
    n_cmp++; if (b8.done !== 4'b0001) begin n_err++; $display("FAIL rot_done_r0 got=%b exp=0001", b8.done); end
    n_cmp++; if (b8.q !== 8'h00) begin n_err++; $display("FAIL rot_q_hold got=%h exp=00", b8.q); end
    $display("test_rotation: r2 then r3 then r0, q=%h", b8.q);
  endtask

  task automatic test_out_of_range();
    b6.req_valid[1]   = 1'b1;
    b6.req_idx[3 +: 3] = 3'd7;
    b6.req_jk[2 +: 2]  = 2'b10;
    #1;
    n_cmp++; if (b6.req_ready !== 4'b0010) begin n_err++; $display("FAIL oor_ready got=%b exp=0010", b6.req_ready); end
    tick();
    b6.req_valid = '0;
    tick();
    n_cmp++; if (b6.q !== 6'h00) begin n_err++; $display("FAIL oor_q got=%h exp=00", b6.q); end
    n_cmp++; if (b6.err !== 1'b1) begin n_err++; $display("FAIL oor_err got=%b exp=1", b6.err); end
    n_cmp++; if (b6.done !== 4'b0010) begin n_err++; $display("FAIL oor_done got=%b exp=0010", b6.done); end
    tick();
    n_cmp++; if (b6.err !== 1'b1) begin n_err++; $display("FAIL oor_err_sticky got=%b exp=1", b6.err); end
    n_cmp++; if (b6.done !== 4'b0000) begin n_err++; $display("FAIL oor_done_pulse got=%b exp=0000", b6.done); end
    do_reset();
    #1;
    n_cmp++; if (b6.err !== 1'b0) begin n_err++; $display("FAIL oor_err_cleared got=%b exp=0", b6.err); end
    $display("test_out_of_range: idx=7 on 6 cells, err cleared by reset");
  endtask

  task automatic test_reset_mid();
    set8(1, 3'd5, 2'b10);
    #1;
    tick();
    clr8();
    set8(0, 3'd0, 2'b00);
    set8(2, 3'd0, 2'b00);
    rst = 1'b1;
    #1;
    n_cmp++; if (b8.req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_ready_in_rst got=%b exp=0000", b8.req_ready); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (b8.q !== 8'h00) begin n_err++; $display("FAIL mid_q got=%h exp=00", b8.q); end
    n_cmp++; if (b8.done !== 4'b0000) begin n_err++; $display("FAIL mid_done got=%b exp=0000", b8.done); end
    n_cmp++; if (b8.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got=%b exp=0", b8.busy); end
    n_cmp++; if (b8.req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_ptr got=%b exp=0001", b8.req_ready); end
    clr8();
    tick();
    $display("test_reset_mid: pending command discarded");
  endtask

  task automatic test_back_to_back();
    set8(0, 3'd6, 2'b11);
    #1;
    tick();
    tick();
    clr8();
    n_cmp++; if (b8.q !== 8'h40) begin n_err++; $display("FAIL b2b_first got=%h exp=40", b8.q); end
    n_cmp++; if (b8.busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got=%b exp=1", b8.busy); end
    tick();
    n_cmp++; if (b8.q !== 8'h00) begin n_err++; $display("FAIL b2b_second got=%h exp=00", b8.q); end
    n_cmp++; if (b8.done !== 4'b0001) begin n_err++; $display("FAIL b2b_done got=%b exp=0001", b8.done); end
    $display("test_back_to_back: two toggles on cell 6, q=%h", b8.q);
  endtask

  initial begin
    b8.req_valid = '0; b8.req_idx = '0; b8.req_jk = '0;
    b6.req_valid = '0; b6.req_idx = '0; b6.req_jk = '0;
    test_reset();
    test_single();
    test_jk_table();
    test_fairness();
    test_rotation();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
